// File: rtl/pong_pkg.sv
// Shared quadrature definitions for the pong front-end: Gray-code states,
// detent default and the single-step transition decoder.
package pong_pkg;

  localparam logic [1:0] QA_00 = 2'b00;
  localparam logic [1:0] QA_01 = 2'b01;
  localparam logic [1:0] QA_11 = 2'b11;
  localparam logic [1:0] QA_10 = 2'b10;

  // Pull-ups hold both channels high at a detent.
  localparam logic [1:0] IDLE_AB_DEFAULT = QA_11;

  typedef struct packed {
    logic signed [1:0] delta;
    logic              illegal;
  } quad_t;

  // Forward order is 00 -> 01 -> 11 -> 10 -> 00; any other single-bit change
  // is necessarily the reverse of one of those.
  function automatic quad_t quad_delta(input logic [1:0] prev, input logic [1:0] curr);
    quad_t r;
    r.delta   = 2'sb00;
    r.illegal = 1'b0;
    if (prev != curr) begin
      if ((prev ^ curr) == 2'b11) begin
        r.illegal = 1'b1;
      end else begin
        case ({prev, curr})
          {QA_00, QA_01},
          {QA_01, QA_11},
          {QA_11, QA_10},
          {QA_10, QA_00}: r.delta = 2'sb01;
          default:        r.delta = 2'sb11;
        endcase
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rotary_encoder_debounce.sv
// One encoder channel: 2-flop synchroniser followed by a stability filter that
// accepts a new level only after DEBOUNCE_CYCLES consecutive differing samples.
module debounce #(
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic filtered
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RESET_LEVEL;
      sync <= RESET_LEVEL;
    end else begin
      meta <= pin;
      sync <= meta;
    end
  end

  // Any sample matching the accepted level restarts the count, so a bounce
  // shorter than the window leaves no trace.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      filtered <= RESET_LEVEL;
    end else if (sync == filtered) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      filtered <= sync;
      cnt      <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/rotary_encoder.sv
// Quadrature front-end: debounced decode into a wrapping 2-bit position,
// optionally divided so one step needs 2^DIV_LOG2 net transitions.
module rotary_encoder
  import pong_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = 16,
  parameter int         DIV_LOG2        = 0,
  parameter logic [1:0] IDLE_AB         = IDLE_AB_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enc_a,
  input  logic              enc_b,
  output logic signed [1:0] value,
  output logic              step,
  output logic              dir,
  output logic              glitch
);

  localparam int                     SW      = DIV_LOG2 + 2;
  localparam logic signed [SW-1:0]   SUB_POS = SW'(1 << DIV_LOG2);
  localparam logic signed [SW-1:0]   SUB_NEG = -SUB_POS;

  logic [1:0]           ab;
  logic [1:0]           ab_prev;
  logic signed [SW-1:0] sub;
  logic signed [SW-1:0] sub_sum;
  quad_t                q;
  logic                 count_vld;
  logic                 wrap_hit;

  debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_LEVEL    (IDLE_AB[1])
  ) u_deb_a (
    .clk     (clk),
    .reset   (reset),
    .pin     (enc_a),
    .filtered(ab[1])
  );

  debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_LEVEL    (IDLE_AB[0])
  ) u_deb_b (
    .clk     (clk),
    .reset   (reset),
    .pin     (enc_b),
    .filtered(ab[0])
  );

  always_comb begin
    q         = quad_delta(ab_prev, ab);
    count_vld = (q.delta != 2'sb00);
    sub_sum   = sub + SW'($signed(q.delta));
    wrap_hit  = count_vld && ((sub_sum == SUB_POS) || (sub_sum == SUB_NEG));
  end

  // A reversal subtracts from the partial count, so back-and-forth jitter
  // inside one division never produces a step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ab_prev <= IDLE_AB;
      sub     <= '0;
      value   <= 2'sb00;
      step    <= 1'b0;
      dir     <= 1'b0;
      glitch  <= 1'b0;
    end else begin
      ab_prev <= ab;
      step    <= 1'b0;
      glitch  <= q.illegal;
      if (wrap_hit) begin
        value <= value + q.delta;
        step  <= 1'b1;
        dir   <= ~q.delta[1];
        sub   <= '0;
      end else if (count_vld) begin
        sub <= sub_sum;
      end
    end
  end

endmodule

// File: tb/tb_rotary_encoder.sv
// Scoreboard bench for rotary_encoder: one undivided and one divide-by-4 instance.
module tb_rotary_encoder;

  localparam int DB = 4;

  typedef struct packed {
    int         cyc;
    logic [1:0] kind;  // {glitch, step}
    logic [1:0] val;
    logic       dr;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic a0 = 1'b1, b0 = 1'b1, a1 = 1'b1, b1 = 1'b1;
  logic signed [1:0] v0, v1;
  logic s0, s1, d0, d1, g0, g1;

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  ev_t exp0[$], obs0[$], exp1[$], obs1[$];
  ev_t e, o;

  rotary_encoder #(.DEBOUNCE_CYCLES(DB), .DIV_LOG2(0), .IDLE_AB(2'b11)) dut0 (
    .clk(clk), .reset(reset), .enc_a(a0), .enc_b(b0),
    .value(v0), .step(s0), .dir(d0), .glitch(g0)
  );

  rotary_encoder #(.DEBOUNCE_CYCLES(DB), .DIV_LOG2(2), .IDLE_AB(2'b11)) dut1 (
    .clk(clk), .reset(reset), .enc_a(a1), .enc_b(b1),
    .value(v1), .step(s1), .dir(d1), .glitch(g1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      if (s0 | g0) obs0.push_back('{cyc, {g0, s0}, v0, d0});
      if (s1 | g1) obs1.push_back('{cyc, {g1, s1}, v1, d1});
    end
  end

  // Pin change issued at a falling edge: output expected DB+2 rising edges after the next one.
  task automatic drive0(input logic [1:0] ab, input logic [1:0] kind, input logic [1:0] val,
                        input logic dr, input int hold);
    a0 = ab[1];
    b0 = ab[0];
    if (kind != 2'b00) exp0.push_back('{cyc + DB + 3, kind, val, dr});
    repeat (hold) @(negedge clk);
  endtask

  task automatic drive1(input logic [1:0] ab, input logic [1:0] kind, input logic [1:0] val,
                        input logic dr, input int hold);
    a1 = ab[1];
    b1 = ab[0];
    if (kind != 2'b00) exp1.push_back('{cyc + DB + 3, kind, val, dr});
    repeat (hold) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (5) @(negedge clk);
    tests++;
    if ({v0, s0, g0, d0} !== 5'b0) begin
      fails++;
      $display("FAIL reset_dut0: value=%b step=%b glitch=%b dir=%b, expected all 0", v0, s0, g0, d0);
    end
    tests++;
    if ({v1, s1, g1, d1} !== 5'b0) begin
      fails++;
      $display("FAIL reset_dut1: value=%b step=%b glitch=%b dir=%b, expected all 0", v1, s1, g1, d1);
    end
    reset = 1'b1;
    repeat (50) @(negedge clk);
    tests++;
    if (obs0.size() != 0 || obs1.size() != 0) begin
      fails++;
      $display("FAIL reset_release_quiet: %0d/%0d events seen, expected 0/0", obs0.size(), obs1.size());
    end
    obs0.delete();
    obs1.delete();
  endtask

  task automatic test_sequence();
    drive0(2'b10, 2'b01, 2'b01, 1'b1, 10);
    drive0(2'b00, 2'b01, 2'b10, 1'b1, 10);
    drive0(2'b01, 2'b01, 2'b11, 1'b1, 10);
    drive0(2'b11, 2'b01, 2'b00, 1'b1, 10);
    tests++;
    if (v0 !== 2'sb00 || d0 !== 1'b1) begin
      fails++;
      $display("FAIL fwd_final: value=%b dir=%b, expected 00 1", v0, d0);
    end
    drive0(2'b01, 2'b01, 2'b11, 1'b0, 10);
    drive0(2'b00, 2'b01, 2'b10, 1'b0, 10);
    drive0(2'b10, 2'b01, 2'b01, 1'b0, 10);
    drive0(2'b11, 2'b01, 2'b00, 1'b0, 10);
    tests++;
    if (v0 !== 2'sb00 || d0 !== 1'b0) begin
      fails++;
      $display("FAIL rev_final: value=%b dir=%b, expected 00 0", v0, d0);
    end
    tests++;
    if (obs0.size() != exp0.size()) begin
      fails++;
      $display("FAIL seq_count: got %0d events, expected %0d", obs0.size(), exp0.size());
    end
    while (exp0.size() > 0 && obs0.size() > 0) begin
      e = exp0.pop_front();
      o = obs0.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL seq_event: got cyc=%0d kind=%b value=%b dir=%b, expected cyc=%0d kind=%b value=%b dir=%b",
                 o.cyc, o.kind, o.val, o.dr, e.cyc, e.kind, e.val, e.dr);
      end
    end
    exp0.delete();
    obs0.delete();
  endtask

  task automatic test_bounce();
    drive0(2'b10, 2'b00, 2'b00, 1'b0, 3);
    drive0(2'b11, 2'b00, 2'b00, 1'b0, 15);
    tests++;
    if (obs0.size() != 0 || v0 !== 2'sb00) begin
      fails++;
      $display("FAIL bounce_short: %0d events value=%b, expected 0 events value 00", obs0.size(), v0);
    end
    drive0(2'b10, 2'b01, 2'b01, 1'b1, 4);
    drive0(2'b11, 2'b01, 2'b00, 1'b0, 12);
    tests++;
    if (obs0.size() != exp0.size()) begin
      fails++;
      $display("FAIL bounce_count: got %0d events, expected %0d", obs0.size(), exp0.size());
    end
    while (exp0.size() > 0 && obs0.size() > 0) begin
      e = exp0.pop_front();
      o = obs0.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL bounce_event: got cyc=%0d kind=%b value=%b dir=%b, expected cyc=%0d kind=%b value=%b dir=%b",
                 o.cyc, o.kind, o.val, o.dr, e.cyc, e.kind, e.val, e.dr);
      end
    end
    exp0.delete();
    obs0.delete();
  endtask

  task automatic test_illegal();
    drive0(2'b00, 2'b10, 2'b00, 1'b0, 12);
    tests++;
    if (v0 !== 2'sb00) begin
      fails++;
      $display("FAIL illegal_value: value=%b, expected 00", v0);
    end
    drive0(2'b01, 2'b01, 2'b01, 1'b1, 12);
    drive0(2'b11, 2'b01, 2'b10, 1'b1, 12);
    tests++;
    if (obs0.size() != exp0.size()) begin
      fails++;
      $display("FAIL illegal_count: got %0d events, expected %0d", obs0.size(), exp0.size());
    end
    while (exp0.size() > 0 && obs0.size() > 0) begin
      e = exp0.pop_front();
      o = obs0.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL illegal_event: got cyc=%0d kind=%b value=%b dir=%b, expected cyc=%0d kind=%b value=%b dir=%b",
                 o.cyc, o.kind, o.val, o.dr, e.cyc, e.kind, e.val, e.dr);
      end
    end
    exp0.delete();
    obs0.delete();
  endtask

  task automatic test_divider();
    drive1(2'b10, 2'b00, 2'b00, 1'b0, 10);
    drive1(2'b00, 2'b00, 2'b00, 1'b0, 10);
    drive1(2'b01, 2'b00, 2'b00, 1'b0, 10);
    drive1(2'b11, 2'b01, 2'b01, 1'b1, 10);
    drive1(2'b10, 2'b00, 2'b00, 1'b0, 10);
    drive1(2'b00, 2'b00, 2'b00, 1'b0, 10);
    drive1(2'b10, 2'b00, 2'b00, 1'b0, 10);
    drive1(2'b11, 2'b00, 2'b00, 1'b0, 10);
    tests++;
    if (v1 !== 2'sb01 || dut1.sub !== 4'sd0) begin
      fails++;
      $display("FAIL div_state: value=%b sub=%0d, expected 01 and 0", v1, dut1.sub);
    end
    tests++;
    if (obs1.size() != exp1.size()) begin
      fails++;
      $display("FAIL div_count: got %0d events, expected %0d", obs1.size(), exp1.size());
    end
    while (exp1.size() > 0 && obs1.size() > 0) begin
      e = exp1.pop_front();
      o = obs1.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL div_event: got cyc=%0d kind=%b value=%b dir=%b, expected cyc=%0d kind=%b value=%b dir=%b",
                 o.cyc, o.kind, o.val, o.dr, e.cyc, e.kind, e.val, e.dr);
      end
    end
    exp1.delete();
    obs1.delete();
  endtask

  task automatic test_async_reset();
    drive0(2'b10, 2'b01, 2'b11, 1'b1, 10);
    tests++;
    if (obs0.size() != exp0.size()) begin
      fails++;
      $display("FAIL areset_pre_count: got %0d events, expected %0d", obs0.size(), exp0.size());
    end
    while (exp0.size() > 0 && obs0.size() > 0) begin
      e = exp0.pop_front();
      o = obs0.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL areset_pre_event: got cyc=%0d kind=%b value=%b dir=%b, expected cyc=%0d kind=%b value=%b dir=%b",
                 o.cyc, o.kind, o.val, o.dr, e.cyc, e.kind, e.val, e.dr);
      end
    end
    exp0.delete();
    obs0.delete();
    // dut0 mid-debounce, dut1 holding a partial division count
    drive0(2'b00, 2'b00, 2'b00, 1'b0, 0);
    drive1(2'b10, 2'b00, 2'b00, 1'b0, 3);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({v0, s0, g0, d0} !== 5'b0) begin
      fails++;
      $display("FAIL areset_dut0: value=%b step=%b glitch=%b dir=%b, expected all 0", v0, s0, g0, d0);
    end
    tests++;
    if ({v1, s1, g1, d1} !== 5'b0 || dut1.sub !== 4'sd0) begin
      fails++;
      $display("FAIL areset_dut1: value=%b dir=%b sub=%0d, expected 00 0 0", v1, d1, dut1.sub);
    end
    @(negedge clk);
    a0 = 1'b1; b0 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (50) @(negedge clk);
    tests++;
    if (obs0.size() != 0 || obs1.size() != 0 || v0 !== 2'sb00 || v1 !== 2'sb00) begin
      fails++;
      $display("FAIL areset_release_quiet: events %0d/%0d values %b/%b, expected 0/0 00/00",
               obs0.size(), obs1.size(), v0, v1);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_sequence();
    test_bounce();
    test_illegal();
    test_divider();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
